// File: rtl/alu_op_issue_ctrl.sv
// Registered ALU opcode issue stage: decodes opcodes to an op class and issues them downstream.
// Optional sticky illegal-opcode trap is enabled by defining ALU_OPC_TRAP_EN.
module alu_op_issue_ctrl #(
    parameter int OPC_W     = 4,
    parameter int ALUOP_W   = 2,
    parameter int MC_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    input  logic [OPC_W-1:0]   opcode,
    output logic               op_ready,
    output logic               aluop_valid,
    output logic [ALUOP_W-1:0] aluop,
    input  logic               aluop_ready,
    output logic               busy,
    output logic               illegal
`ifdef ALU_OPC_TRAP_EN
    ,
    input  logic               trap_clr
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and aluop is held stable while aluop_valid & !aluop_ready.

    localparam int CNT_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_MULTI
    } state_t;

    state_t             state_q, state_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               illegal_q, illegal_d;
    logic               dec_legal;
    logic [1:0]         dec_cls;
    logic               mc_q;
    logic               trap_blk;
    logic               accept;

    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = 2'd0;
        case (opcode[3:0])
            4'd1, 4'd8, 4'd9, 4'd10:  dec_cls = 2'd0;
            4'd2, 4'd5, 4'd11, 4'd12: dec_cls = 2'd1;
            4'd3:                     dec_cls = 2'd2;
            4'd4:                     dec_cls = 2'd3;
            default:                  dec_legal = 1'b0;
        endcase
        // Any bit above the 4-bit opcode space makes the opcode illegal.
        if ((opcode >> 4) != '0) dec_legal = 1'b0;
    end

    assign mc_q = (aluop_q[1:0] == 2'd3);

`ifdef ALU_OPC_TRAP_EN
    assign trap_blk = illegal_q;
`else
    assign trap_blk = 1'b0;
`endif

    assign op_ready = ((state_q == S_IDLE) && !trap_blk) ||
                      ((state_q == S_ISSUE) && aluop_ready && !mc_q);
    assign accept   = op_valid && op_ready;

    always_comb begin
        state_d = state_q;
        aluop_d = aluop_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept && dec_legal) begin
                    state_d = S_ISSUE;
                    aluop_d = ALUOP_W'(dec_cls);
                end
            end
            S_ISSUE: begin
                if (aluop_ready) begin
                    if (mc_q) begin
                        state_d = S_MULTI;
                        cnt_d   = CNT_LOAD;
                    end else if (accept && dec_legal) begin
                        aluop_d = ALUOP_W'(dec_cls);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_MULTI: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ALU_OPC_TRAP_EN
    always_comb begin
        illegal_d = illegal_q;
        if (accept && !dec_legal) illegal_d = 1'b1;
        else if (trap_clr)        illegal_d = 1'b0;
    end
`else
    always_comb begin
        illegal_d = accept && !dec_legal;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            aluop_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aluop_q   <= aluop_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign aluop_valid = (state_q == S_ISSUE);
    assign aluop       = aluop_q;
    assign busy        = (state_q == S_MULTI);
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_op_issue_ctrl.sv
// Bench for alu_op_issue_ctrl: directed steps plus a small random burst, scoreboarded issues.
module tb_alu_op_issue_ctrl;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic [3:0] opcode;
  logic       op_ready;
  logic       aluop_valid;
  logic [1:0] aluop;
  logic       aluop_ready;
  logic       busy;
  logic       illegal;
  logic       trap_clr;

  int checks;
  int failures;
  logic [1:0] exp_q[$];

  alu_op_issue_ctrl #(.OPC_W(4), .ALUOP_W(2), .MC_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .opcode      (opcode),
    .op_ready    (op_ready),
    .aluop_valid (aluop_valid),
    .aluop       (aluop),
    .aluop_ready (aluop_ready),
    .busy        (busy),
    .illegal     (illegal)
`ifdef ALU_OPC_TRAP_EN
    ,
    .trap_clr    (trap_clr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int model_cls(input logic [3:0] op);
    case (op)
      4'd1, 4'd8, 4'd9, 4'd10:  return 0;
      4'd2, 4'd5, 4'd11, 4'd12: return 1;
      4'd3:                     return 2;
      4'd4:                     return 3;
      default:                  return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sampled at the falling edge: records what the coming rising edge will transfer.
  task automatic sb_sample();
    logic [1:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (aluop_valid && aluop_ready) begin
        chk("sb_have_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_aluop", aluop, e);
        end
      end
      if (op_valid && op_ready && model_cls(opcode) >= 0)
        exp_q.push_back(2'(model_cls(opcode)));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op);
    op_valid = 1'b1;
    opcode   = op;
    tick();
    op_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] leg_tab[3];
    logic [1:0] cls_tab[3];
    logic [3:0] ill_tab[3];
    logic [3:0] rop;
    bit         acc;
    int         waited;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    op_valid = 1'b0;
    opcode = 4'd0;
    aluop_ready = 1'b0;
    trap_clr = 1'b0;
    tick();
    tick();
    chk("rst_aluop_valid", aluop_valid, 0);
    chk("rst_aluop", aluop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_op_ready", op_ready, 1);
    rst_n = 1'b1;

    // Single legal opcodes, one cycle latency to aluop_valid
    leg_tab = '{4'd9, 4'd11, 4'd3};
    cls_tab = '{2'd0, 2'd1, 2'd2};
    aluop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(leg_tab[i]);
      chk("lat_valid", aluop_valid, 1);
      chk("lat_aluop", aluop, cls_tab[i]);
      tick();
      chk("lat_done", aluop_valid, 0);
    end

    // Multi-cycle class with upstream holding a pending opcode
    send(4'd4);
    chk("mc_aluop", aluop, 3);
    chk("mc_valid", aluop_valid, 1);
    op_valid = 1'b1;
    opcode = 4'd1;
    #1;
    chk("mc_issue_ready", op_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mc_busy", busy, 1);
      chk("mc_ready", op_ready, 0);
      chk("mc_valid_low", aluop_valid, 0);
    end
    tick();
    chk("mc_end_busy", busy, 0);
    chk("mc_end_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    chk("mc_pending_valid", aluop_valid, 1);
    chk("mc_pending_aluop", aluop, 0);
    tick();

    // Backpressure holds the issued op
    aluop_ready = 1'b0;
    send(4'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", aluop_valid, 1);
      chk("bp_aluop", aluop, 1);
      chk("bp_ready", op_ready, 0);
      tick();
    end
    aluop_ready = 1'b1;
    #1;
    chk("bp_release_ready", op_ready, 1);
    tick();
    chk("bp_done", aluop_valid, 0);

    // Back-to-back issue without bubbles
    op_valid = 1'b1;
    opcode = 4'd1;
    tick();
    chk("b2b_a", aluop, 0);
    opcode = 4'd5;
    #1;
    chk("b2b_ready", op_ready, 1);
    tick();
    chk("b2b_b_valid", aluop_valid, 1);
    chk("b2b_b", aluop, 1);
    opcode = 4'd3;
    tick();
    chk("b2b_c_valid", aluop_valid, 1);
    chk("b2b_c", aluop, 2);
    op_valid = 1'b0;
    tick();
    chk("b2b_done", aluop_valid, 0);

    // Reset in the middle of a multi-cycle op
    send(4'd4);
    tick();
    tick();
    chk("rstm_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    tick();
    chk("rstm_busy", busy, 0);
    chk("rstm_valid", aluop_valid, 0);
    chk("rstm_aluop", aluop, 0);
    chk("rstm_illegal", illegal, 0);
    rst_n = 1'b1;
    chk("rstm_ready", op_ready, 1);

    // Reset while an op waits in ISSUE drops it
    aluop_ready = 1'b0;
    send(4'd12);
    chk("rsti_valid_before", aluop_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rsti_valid", aluop_valid, 0);
    chk("rsti_aluop", aluop, 0);
    aluop_ready = 1'b1;

    // Illegal opcodes
    ill_tab = '{4'd13, 4'd0, 4'd6};
`ifdef ALU_OPC_TRAP_EN
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    chk("trap_noop_illegal", illegal, 0);
    chk("trap_noop_ready", op_ready, 1);
    for (int i = 0; i < 3; i++) begin
      send(ill_tab[i]);
      op_valid = 1'b1;
      opcode = 4'd10;
      for (int k = 0; k < 3; k++) begin
        chk("trap_illegal", illegal, 1);
        chk("trap_ready", op_ready, 0);
        chk("trap_valid", aluop_valid, 0);
        tick();
      end
      op_valid = 1'b0;
      trap_clr = 1'b1;
      tick();
      trap_clr = 1'b0;
      chk("trap_clr_illegal", illegal, 0);
      chk("trap_clr_ready", op_ready, 1);
      send(4'd10);
      chk("trap_next_aluop", aluop, 0);
      tick();
    end
`else
    for (int i = 0; i < 3; i++) begin
      send(ill_tab[i]);
      chk("ill_pulse", illegal, 1);
      chk("ill_valid", aluop_valid, 0);
      chk("ill_ready", op_ready, 1);
      tick();
      chk("ill_pulse_end", illegal, 0);
      send(4'd10);
      chk("ill_next_valid", aluop_valid, 1);
      chk("ill_next_aluop", aluop, 0);
      tick();
    end
`endif

    // Random legal opcodes with random downstream stalls
    for (int n = 0; n < 25; n++) begin
      rop = 4'($urandom_range(1, 12));
      while (model_cls(rop) < 0) rop = 4'($urandom_range(1, 12));
      op_valid = 1'b1;
      opcode = rop;
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < 50) begin
        aluop_ready = 1'($urandom_range(0, 1));
        #1;
        acc = op_ready;
        tick();
        waited++;
      end
      chk("rand_accept_timeout", acc, 1);
    end
    op_valid = 1'b0;
    aluop_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("sb_drain", exp_q.size(), 0);
    chk("final_idle_ready", op_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
